// File: rtl/rf_wb_arbiter_if.sv
// Register-file write-back bus. It carries the pipeline write-back, the multi-cycle
// valid/ready handshake, the merged RF write port, the pending mask and the error flag.
interface rf_wb_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic                  pipe_wr_en;
  logic [SEL_W-1:0]      pipe_wr_sel;
  logic [DATA_W-1:0]     pipe_wr_data;
  logic                  mc_valid;
  logic [SEL_W-1:0]      mc_sel;
  logic [DATA_W-1:0]     mc_data;
  logic                  mc_ready;
  logic                  write;
  logic [SEL_W-1:0]      writeregsel;
  logic [DATA_W-1:0]     writedata;
  logic [2**SEL_W-1:0]   pend_mask;
  logic                  err;

  modport master (
    output pipe_wr_en, pipe_wr_sel, pipe_wr_data, mc_valid, mc_sel, mc_data,
    input  mc_ready, write, writeregsel, writedata, pend_mask, err
  );

  modport slave (
    input  pipe_wr_en, pipe_wr_sel, pipe_wr_data, mc_valid, mc_sel, mc_data,
    output mc_ready, write, writeregsel, writedata, pend_mask, err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Merges the never-stalling pipeline write-back and a FIFO-buffered multi-cycle unit
// onto one RF write port, with WAW squash, a pending-register mask and a starvation flag.
module rf_wb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int SEL_W      = 3,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic   clk,
  input  logic   rst,
  rf_wb_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam int NREG  = 2**SEL_W;

  typedef struct packed {
    logic              live;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t             fifo [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;
  logic             err_q;

  logic             full, empty, push, pop;
  logic [NREG-1:0]  pm;
  ent_t             head;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = fifo[rd_ptr];

  // Pipeline always wins the port; the FIFO head only drains in idle pipe slots.
  assign push = bus.mc_valid && !full && !rst;
  assign pop  = !bus.pipe_wr_en && !empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      starve <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo[i].live <= 1'b0;
    end else begin
      // Squash first so an entry enqueued on this same edge keeps its live bit.
      for (int i = 0; i < DEPTH; i++)
        if (bus.pipe_wr_en && fifo[i].sel == bus.pipe_wr_sel) fifo[i].live <= 1'b0;
      if (pop) begin
        fifo[rd_ptr].live <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        fifo[wr_ptr] <= '{live: 1'b1, sel: bus.mc_sel, data: bus.mc_data};
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);

      if (pop)
        starve <= '0;
      else if (full && bus.pipe_wr_en && starve != STV_W'(STARVE_MAX))
        starve <= starve + STV_W'(1);
      if (full && bus.pipe_wr_en && starve >= STV_W'(STARVE_MAX - 1))
        err_q <= 1'b1;
    end
  end

  // Live bits are cleared on pop, so only occupied slots can contribute.
  always_comb begin
    pm = '0;
    for (int i = 0; i < DEPTH; i++)
      if (fifo[i].live) pm[fifo[i].sel] = 1'b1;
  end

  always_comb begin
    bus.write       = 1'b0;
    bus.writeregsel = '0;
    bus.writedata   = '0;
    if (!rst) begin
      if (bus.pipe_wr_en) begin
        bus.write       = 1'b1;
        bus.writeregsel = bus.pipe_wr_sel;
        bus.writedata   = bus.pipe_wr_data;
      end else if (!empty) begin
        bus.write       = head.live;
        bus.writeregsel = head.sel;
        bus.writedata   = head.data;
      end
    end
  end

  assign bus.mc_ready  = !full && !rst;
  assign bus.pend_mask = rst ? '0 : pm;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus randomized bench for rf_wb_arbiter; a queue-based reference model
// predicts the RF port, handshake, pending mask and error flag every cycle.
module tb_rf_wb_arbiter;
  localparam int DATA_W = 16, SEL_W = 3, DEPTH = 2, STARVE_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wb_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  rf_wb_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    bit                live;
  } m_ent_t;

  m_ent_t q[$];
  bit     err_m;
  int     starve_m;
  bit     acc;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0]  pm;
    logic        w;
    logic [2:0]  s;
    logic [15:0] d;
    pm = '0; w = 0; s = '0; d = '0;
    if (!rst) begin
      foreach (q[i]) if (q[i].live) pm[q[i].sel] = 1'b1;
      if (bus.pipe_wr_en) begin
        w = 1; s = bus.pipe_wr_sel; d = bus.pipe_wr_data;
      end else if (q.size() > 0) begin
        w = q[0].live; s = q[0].sel; d = q[0].data;
      end
    end
    chk("m_ready", 32'(bus.mc_ready), 32'(!rst && q.size() < DEPTH));
    chk("m_write", 32'(bus.write), 32'(w));
    chk("m_sel",   32'(bus.writeregsel), 32'(s));
    chk("m_data",  32'(bus.writedata), 32'(d));
    chk("m_pend",  32'(bus.pend_mask), 32'(pm));
    chk("m_err",   32'(bus.err), 32'(err_m));
  endtask

  task automatic update_model();
    bit full, pop;
    m_ent_t e;
    acc = 0;
    if (rst) begin
      q.delete(); err_m = 0; starve_m = 0;
      return;
    end
    full = (q.size() == DEPTH);
    acc  = bus.mc_valid && !full;
    pop  = !bus.pipe_wr_en && q.size() > 0;
    if (pop) starve_m = 0;
    else if (full && bus.pipe_wr_en) begin
      starve_m++;
      if (starve_m >= STARVE_MAX) err_m = 1;
    end
    if (bus.pipe_wr_en)
      foreach (q[i]) if (q[i].sel == bus.pipe_wr_sel) q[i].live = 0;
    if (pop) void'(q.pop_front());
    if (acc) begin
      e.sel = bus.mc_sel; e.data = bus.mc_data; e.live = 1;
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_pipe(input bit en, input logic [2:0] s, input logic [15:0] d);
    bus.pipe_wr_en = en; bus.pipe_wr_sel = s; bus.pipe_wr_data = d;
  endtask

  task automatic set_mc(input bit v, input logic [2:0] s, input logic [15:0] d);
    bus.mc_valid = v; bus.mc_sel = s; bus.mc_data = d;
  endtask

  initial begin
    set_pipe(0, 0, 0);
    set_mc(0, 0, 0);
    rst = 1;
    #1;
    chk("rst_write", 32'(bus.write), 0);
    chk("rst_ready", 32'(bus.mc_ready), 0);
    chk("rst_pend",  32'(bus.pend_mask), 0);
    tick(); tick();
    rst = 0;
    #1;
    chk("post_rst_err", 32'(bus.err), 0);
    chk("post_rst_ready", 32'(bus.mc_ready), 1);

    // Pipe-only write appears in the same cycle.
    set_pipe(1, 3, 16'hBEEF); #1;
    chk("t1_write", 32'(bus.write), 1);
    chk("t1_sel",   32'(bus.writeregsel), 3);
    chk("t1_data",  32'(bus.writedata), 32'h0000BEEF);
    tick();

    // Multi-cycle accept, written one cycle later.
    set_pipe(0, 0, 0); set_mc(1, 5, 16'h1234); #1;
    chk("t2_ready", 32'(bus.mc_ready), 1);
    chk("t2_nowrite", 32'(bus.write), 0);
    tick();
    set_mc(0, 0, 0); #1;
    chk("t2_write", 32'(bus.write), 1);
    chk("t2_sel",   32'(bus.writeregsel), 5);
    chk("t2_data",  32'(bus.writedata), 32'h00001234);
    chk("t2_pend",  32'(bus.pend_mask), 32'h20);
    tick(); #1;
    chk("t2_pend_clr", 32'(bus.pend_mask), 0);
    chk("t2_idle", 32'(bus.write), 0);

    // Backpressure while pipe is busy, then in-order drain.
    set_pipe(1, 1, 16'h0001); set_mc(1, 6, 16'h000A); tick();
    set_mc(1, 7, 16'h000B); tick();
    set_mc(0, 0, 0); #1;
    chk("t3_full", 32'(bus.mc_ready), 0);
    tick();
    set_pipe(0, 0, 0); #1;
    chk("t3_d0_sel",  32'(bus.writeregsel), 6);
    chk("t3_d0_data", 32'(bus.writedata), 32'h000A);
    tick(); #1;
    chk("t3_d1_sel",  32'(bus.writeregsel), 7);
    chk("t3_d1_data", 32'(bus.writedata), 32'h000B);
    chk("t3_ready",   32'(bus.mc_ready), 1);
    tick(); #1;
    chk("t3_empty", 32'(bus.write), 0);

    // WAW squash of a queued entry; same-edge enqueue survives.
    set_pipe(1, 4, 16'h0044); set_mc(1, 2, 16'h0022); tick();
    set_mc(0, 0, 0); set_pipe(1, 2, 16'h0099); #1;
    chk("t4_pend_set", 32'(bus.pend_mask), 32'h04);
    tick(); #1;
    chk("t4_pend_clr", 32'(bus.pend_mask), 0);
    set_pipe(0, 0, 0); #1;
    chk("t4_dead_write", 32'(bus.write), 0);
    chk("t4_dead_sel",   32'(bus.writeregsel), 2);
    tick();
    set_pipe(1, 2, 16'h0055); set_mc(1, 2, 16'h0077); tick();
    set_pipe(0, 0, 0); set_mc(0, 0, 0); #1;
    chk("t4_new_write", 32'(bus.write), 1);
    chk("t4_new_data",  32'(bus.writedata), 32'h0077);
    tick();

    // Starvation: full FIFO blocked for STARVE_MAX cycles.
    set_pipe(1, 0, 16'h0F0F); set_mc(1, 1, 16'h0101); tick();
    set_mc(1, 3, 16'h0303); tick();
    set_mc(0, 0, 0);
    for (int i = 0; i < STARVE_MAX - 1; i++) tick();
    chk("t5_err_early", 32'(bus.err), 0);
    tick();
    chk("t5_err_set", 32'(bus.err), 1);
    set_pipe(0, 0, 0); tick(); tick(); #1;
    chk("t5_err_hold", 32'(bus.err), 1);
    chk("t5_drained", 32'(bus.mc_ready), 1);
    rst = 1; tick(); rst = 0; #1;
    chk("t5_err_clr", 32'(bus.err), 0);

    // Reset mid-operation discards queued entries.
    set_pipe(1, 6, 16'h0666); set_mc(1, 4, 16'h0004); tick();
    set_mc(1, 5, 16'h0005); tick();
    set_mc(0, 0, 0); set_pipe(0, 0, 0); rst = 1; #1;
    chk("t6_rst_write", 32'(bus.write), 0);
    chk("t6_rst_pend",  32'(bus.pend_mask), 0);
    tick();
    rst = 0; #1;
    chk("t6_ready", 32'(bus.mc_ready), 1);
    chk("t6_write", 32'(bus.write), 0);
    chk("t6_pend",  32'(bus.pend_mask), 0);
    tick();

    // Randomized traffic; the producer holds a stalled request stable.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      set_pipe($urandom_range(0, 99) < 55, 3'($urandom_range(0, 7)), 16'($urandom));
      if (!(bus.mc_valid && !acc)) begin
        if ($urandom_range(0, 99) < 60) set_mc(1, 3'($urandom_range(0, 7)), 16'($urandom));
        else set_mc(0, 0, 0);
      end
      tick();
    end
    rst = 0;
    set_pipe(0, 0, 0); set_mc(0, 0, 0);
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
